ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit for the execute stage, implementing all eight RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU and branch unit. Its operands come from the execute forwarding selector, already bypassed. It stalls the pipeline while an operation is in flight and presents a registered result and destination for one cycle, ready for the EX/MEM register.

## Interface
- XLEN, 32: operand/result width; must be a power of two, ≥ 8.
- RD_W, 5: destination register address width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  an M-extension instruction is in EX with resolved operands.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  XLEN  forwarded operand 1 (dividend / multiplicand).
- rs2_i  in  XLEN  forwarded operand 2 (divisor / multiplier).
- rd_addr_i  in  RD_W  destination register.
- flush_i  in  1  synchronous kill from the branch unit.
- ready_o  out  1  unit idle; can accept an operation.
- stall_o  out  1  hold upstream stages.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result, held until the next accept.
- rd_addr_o  out  RD_W  destination register for result_o.

## Operation
- FSM states: IDLE, CALC, DONE.
- Accept condition: valid_i & ready_o & ~flush_i. On accept, the unit latches op, rd_addr, operand magnitudes and result sign.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both operands signed.
  - All others: unsigned.
  - Signed operands are converted to magnitudes on accept. The final value is negated in the DONE transition when the result sign is negative.
  - REM takes the sign of the dividend.
- Multiplication: shift-add, one multiplier bit per cycle, 2·XLEN-bit accumulator. MUL returns the low XLEN bits. MULH* return the high XLEN bits of the signed 2·XLEN product.
- Division: restoring, one quotient bit per cycle, XLEN-bit remainder plus one guard bit.
- Special cases bypass CALC (IDLE→DONE directly):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): quotient = rs1; remainder = 0.
- Counter width is $clog2(XLEN+1). It is loaded with XLEN on entry to CALC. CALC→DONE occurs when the counter reaches 1 and that iteration completes.
- DONE→IDLE is unconditional.
- ready_o = (state == IDLE).
- valid_o = (state == DONE) & ~flush_i.
- stall_o = (state == CALC) | (state == IDLE & valid_i & ~flush_i).
- flush_i in any state forces IDLE next cycle. No valid_o is produced for the killed operation, and result_o / rd_addr_o keep their prior values.
- valid_i is ignored in CALC and DONE. The pipeline keeps the instruction in EX, so it is re-presented and accepted in the next IDLE cycle.

## Timing
- Reset values: state IDLE; ready_o 1; stall_o 0 (while valid_i is 0); valid_o 0; result_o 0; rd_addr_o 0; counter 0.
- Reset asserted mid-operation aborts immediately, with no output strobe.
- Accept in cycle N. Iterative path: CALC for cycles N+1 … N+XLEN; DONE with valid_o = 1 in cycle N+XLEN+1. Latency is XLEN+1 cycles, i.e. 33 for XLEN = 32.
- Special-case path: DONE in cycle N+1.
- Back-to-back operations: the earliest next accept is cycle N+XLEN+2.
- stall_o is low in the DONE cycle, so the EX/MEM register captures result_o / rd_addr_o on that edge.
- result_o and rd_addr_o are registered. They update only on the transition into DONE.
- flush_i coincident with DONE suppresses valid_o, and the unit returns to IDLE.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: multiplications use a single-cycle combinational 2·XLEN product. MUL* takes IDLE→DONE with latency 1 cycle. Division is unchanged.
  - Undefined: multiplications use the iterative path with latency XLEN+1.
- The results of both builds are bit-identical.

## Test plan
- MUL 7 × −3 (rs2 = 0xFFFFFFFD), rd = 5 → valid_o in cycle N+33; result_o = 0xFFFFFFEB; rd_addr_o = 5. With MULDIV_FAST_MUL_EN, valid_o is in cycle N+1.
- MULH / MULHSU / MULHU with rs1 = 0x80000000, rs2 = 0xFFFFFFFF → 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU x / 0 → 0xFFFFFFFF. REM 0x1234 / 0 → 0x1234. DIV 0x80000000 / −1 → 0x80000000. All three strobe in cycle N+1.
- Flush during CALC cycle 10:
  - Required: IDLE next cycle; no valid_o; result_o unchanged.
  - A new DIVU 9 / 3 is accepted immediately and returns 3.
- Reset asserted during CALC → all outputs reset asynchronously. Hold valid_i high in CALC and DONE → no accept until IDLE; stall_o stays high through CALC and is low in DONE.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage (shift-add multiply,
// restoring divide). Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RD_W-1:0] rd_addr_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_addr_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: an operation is taken on a rising edge where valid_i & ready_o & ~flush_i;
  // valid_o is a single-cycle strobe and result_o/rd_addr_o hold until the next result.

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        op_q;
  logic              neg_q;
  logic [RD_W-1:0]   rd_q;
  logic [XLEN-1:0]   mag_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;
  logic [RD_W-1:0]   rd_out_q;

  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] prod,
                                              input logic neg, input logic [1:0] op);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_sel(input logic [2*XLEN-1:0] acc,
                                              input logic neg, input logic want_rem);
    logic [XLEN-1:0] r;
    r = want_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    return neg ? -r : r;
  endfunction

  // Operand decode for the incoming instruction.
  logic            in_div, a_sgn, b_sgn, a_neg, b_neg, in_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, one_shot, accept;
  logic [XLEN-1:0] special_res, idle_res;

  always_comb begin
    in_div   = op_i[2];
    a_sgn    = (op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6);
    b_sgn    = (op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6);
    a_neg    = a_sgn & rs1_i[XLEN-1];
    b_neg    = b_sgn & rs2_i[XLEN-1];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
    // Remainder follows the dividend; everything else is the XOR of the operand signs.
    in_neg   = (op_i == 3'd6) ? a_neg : (a_neg ^ b_neg);
    div_zero = in_div & (rs2_i == '0);
    div_ovf  = in_div & ~op_i[0] & (rs1_i == MIN_NEG) & (rs2_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else          special_res = op_i[1] ? '0 : rs1_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    one_shot  = special | ~in_div;
    idle_res  = special ? special_res : mul_sel(fast_prod, in_neg, op_i[1:0]);
  end
`else
  always_comb begin
    one_shot = special;
    idle_res = special_res;
  end
`endif

  // One iteration of the shared datapath: shift-add for multiply, restoring step for divide.
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_q & {XLEN{acc_q[0]}}};
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, mag_q};
    if (op_q[2]) begin
      acc_step = {(div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc_q[XLEN-2:0], ~div_diff[XLEN]};
      calc_res = div_sel(acc_step, neg_q, op_q[1]);
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
      calc_res = mul_sel(acc_step, neg_q, op_q[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = one_shot ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    ready_o     = (state_q == S_IDLE);
    valid_o     = (state_q == S_DONE) & ~flush_i;
    stall_o     = (state_q == S_CALC) | ((state_q == S_IDLE) & valid_i & ~flush_i);
    accept      = valid_i & ready_o & ~flush_i;
    result_o    = result_q;
    rd_addr_o   = rd_out_q;
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_i;
        neg_q <= in_neg;
        rd_q  <= rd_addr_i;
        mag_q <= in_div ? b_mag : a_mag;
        acc_q <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
      end else if (state_q == S_CALC && !flush_i) begin
        acc_q <= acc_step;
      end

      if (state_q == S_IDLE && state_d == S_CALC)   cnt_q <= CW'(XLEN);
      else if (state_q == S_CALC && !flush_i)       cnt_q <= cnt_q - CW'(1);

      // Results land only on the edge that enters DONE.
      if (state_q != S_DONE && state_d == S_DONE) begin
        result_q <= (state_q == S_IDLE) ? idle_res : calc_res;
        rd_out_q <= (state_q == S_IDLE) ? rd_addr_i : rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: latency, results, special cases, flush and reset.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  dbg_state_o;

  int tests = 0;
  int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  ex_muldiv #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_addr_i(rd_addr_i), .flush_i(flush_i), .ready_o(ready_o), .stall_o(stall_o),
    .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o), .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at an IDLE negedge; presents one op, waits for the strobe, checks it, then idles.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_strobe"}, valid_o, 1'b1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_rd"}, rd_addr_o, rd);
    @(negedge clk);
  endtask

  int lat;
  logic stall_ok;

  initial begin
    rst = 1'b0; valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0; flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 1'b1);
    check("rst_stall", stall_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_rd", rd_addr_o, 5'd0);
    check("rst_state", dbg_state_o, 2'd0);
    rst = 1'b1;
    @(negedge clk);

    // IDLE with valid_i high raises stall before the accept edge.
    valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD; rd_addr_i = 5'd5;
    #1 check("idle_stall", stall_o, 1'b1);
    valid_i = 1'b0;
    #1 check("idle_nostall", stall_o, 1'b0);

    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, MUL_LAT);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, MUL_LAT);
    run_op("mulhu",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h7FFF_FFFF, MUL_LAT);
    run_op("mulh_n", 3'd1, 32'hFFFF_FFF9, 32'd3,         5'd9,  32'hFFFF_FFFF, MUL_LAT);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_nd", 3'd4, 32'd7,        32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_nd", 3'd6, 32'd7,        32'hFFFF_FFFE, 5'd13, 32'h0000_0001, DIV_LAT);
    run_op("divu",   3'd5, 32'd100,      32'd7,         5'd14, 32'd14,        DIV_LAT);
    run_op("remu",   3'd7, 32'd100,      32'd7,         5'd15, 32'd2,         DIV_LAT);
    run_op("divu_z", 3'd5, 32'hDEAD_BEEF, 32'd0,        5'd16, 32'hFFFF_FFFF, 1);
    run_op("rem_z",  3'd6, 32'h0000_1234, 32'd0,        5'd17, 32'h0000_1234, 1);
    run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1);
    run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1);

    // Flush during CALC cycle 10: killed op leaves outputs untouched.
    valid_i = 1'b1; op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd10; rd_addr_i = 5'd20;
    @(negedge clk);
    valid_i = 1'b0;
    check("fl_calc", dbg_state_o, 2'd1);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1 check("fl_nostrobe", valid_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    check("fl_idle", dbg_state_o, 2'd0);
    check("fl_ready", ready_o, 1'b1);
    check("fl_res_keep", result_o, 32'h8000_0000);
    check("fl_rd_keep", rd_addr_o, 5'd19);
    run_op("fl_next", 3'd5, 32'd9, 32'd3, 5'd21, 32'd3, DIV_LAT);

    // Flush coincident with DONE suppresses the strobe.
    valid_i = 1'b1; op_i = 3'd5; rs1_i = 32'd5; rs2_i = 32'd0; rd_addr_i = 5'd22;
    @(negedge clk);
    valid_i = 1'b0;
    check("fd_state", dbg_state_o, 2'd2);
    flush_i = 1'b1;
    #1 check("fd_nostrobe", valid_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    check("fd_idle", dbg_state_o, 2'd0);

    // valid_i held high through CALC and DONE; re-accepted on the following IDLE cycle.
    valid_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd23;
    @(negedge clk);
    lat = 1; stall_ok = 1'b1;
    while (!valid_o && lat < 100) begin
      if (!stall_o) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("hold_lat", lat, DIV_LAT);
    check("hold_calc_stall", stall_ok, 1'b1);
    check("hold_done_stall", stall_o, 1'b0);
    check("hold_res", result_o, 32'd14);
    @(negedge clk);
    check("hold_idle_ready", ready_o, 1'b1);
    check("hold_idle_stall", stall_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    check("hold_reaccept", dbg_state_o, 2'd1);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("hold2_lat", lat, DIV_LAT);
    check("hold2_res", result_o, 32'd14);
    @(negedge clk);

    // Asynchronous reset in the middle of CALC.
    valid_i = 1'b1; op_i = 3'd4; rs1_i = 32'd50; rs2_i = 32'd5; rd_addr_i = 5'd24;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_state", dbg_state_o, 2'd0);
    check("ar_ready", ready_o, 1'b1);
    check("ar_stall", stall_o, 1'b0);
    check("ar_valid", valid_o, 1'b0);
    check("ar_result", result_o, 32'h0);
    check("ar_rd", rd_addr_o, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("post_rst", 3'd7, 32'd100, 32'd7, 5'd25, 32'd2, DIV_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
